imem_sched: RTL and testbench
=============================

IMEM_SCHED -- requirements
Module: imem_sched

Interface
REQ-001 Parameter NUM_PE, default 5: number of partial PEs served, IDs 0..NUM_PE-1.
REQ-002 Parameter ROWS_PER_TS, default 5: input rows delivered to each PE per timestep.
REQ-003 Parameter NUM_TS, default 2: timesteps per run.
REQ-004 Parameter IMEM_ID, default 10: this block's 4-bit network address.
REQ-005 Port clk  input  1  sole clock; one clock, all state on rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port start  input  1  one-cycle pulse; begins a run when idle.
REQ-008 Port in_valid / in_ready  input / output  1 / 1  request-packet handshake.
REQ-009 Port in_data  input  33  request packet: [32:29] dest, [28:25] opcode = requesting PE ID, [24:0] ignored.
REQ-010 Port out_valid / out_ready  output / input  1 / 1  outgoing packet handshake.
REQ-011 Port out_data  output  33  packet: [32:29] dest PE, [28:25] opcode, [24:0] data.
REQ-012 Port row_we / row_waddr / row_wdata  input  1 / 5 / 25  ifmap row memory write port (32 x 25 bit).
REQ-013 Port busy  output  1  high from start acceptance until run complete.
REQ-014 Port cur_ts  output  2  current timestep, 0-based.
REQ-015 Port ts_done  output  1  one-cycle pulse after the last timestep-done packet of a timestep is accepted.

Function
REQ-016 A transfer shall occur on a rising edge with valid and ready both high; out_data shall hold stable while out_valid is high and out_ready is low.
REQ-017 FSM states: IDLE, PRIME, SERVE, BCAST, FINISH.
REQ-018 IDLE: start moves to PRIME, clears cur_ts, per-PE row counters and pending bitmap; start outside IDLE is ignored.
REQ-019 PRIME: send one OP_INPUT (1) packet to each PE in order 0..NUM_PE-1, then enter SERVE.
REQ-020 OP_INPUT data for PE p's k-th row (k = that PE's row counter) is row memory[p+k]; the counter increments on acceptance.
REQ-021 in_ready is high in PRIME and SERVE and low otherwise; an accepted request with dest = IMEM_ID, opcode < NUM_PE and counter < ROWS_PER_TS sets that PE's pending bit.
REQ-022 All other accepted requests are dropped.
REQ-023 A repeat request while a PE's bit is already set is absorbed and not duplicated.
REQ-024 SERVE: a round-robin grant over pending bits starts from the PE after the last grant and is registered; out_valid rises the cycle after the grant.
REQ-025 The granted bit clears when the packet is accepted.
REQ-026 If a set and a clear of the same bit occur on one edge, the set wins.
REQ-027 When every counter equals ROWS_PER_TS and no packet is outstanding, move to BCAST.
REQ-028 BCAST: send OP_TIMESTEP_DONE (15), data 0, to PEs 0..NUM_PE-1 in order, then pulse ts_done.
REQ-029 After BCAST, if cur_ts+1 < NUM_TS: increment cur_ts, zero the counters, go to PRIME; else go to FINISH.
REQ-030 FINISH drops busy and returns to IDLE on the next cycle.
REQ-031 Row memory writes are permitted at any time; a write on the edge a packet is formed is not visible to that packet.

Reset
REQ-032 Asserting rst_n low at any time, including mid-packet, forces IDLE immediately.
REQ-033 Reset values: out_valid=0, out_data=0, in_ready=0, busy=0, cur_ts=0, ts_done=0; counters, pending bits and arbiter pointer are zero.
REQ-034 Row memory contents are not reset.

Configuration
REQ-035 With IMEM_SCHED_STATS_EN defined, an output drop_cnt (8 bit) shall count dropped requests, saturate at 255, and clear at start and at reset.
REQ-036 Without IMEM_SCHED_STATS_EN, drop_cnt and its logic are absent.

Structure
REQ-037 Package imem_sched_pkg holds opcode constants (OP_WEIGHT=0, OP_INPUT=1, OP_TIMESTEP_DONE=15), packet field bounds, IMEM_ID, the 25-bit row width and the FSM state enum.
REQ-038 Sub-module rr_arbiter holds the NUM_PE-way round-robin grant logic with its pointer.

Verification
REQ-039 Load row r = r+1 and pulse start, out_ready=1 -> PRIME emits dest 0..4, opcode 1, data 1..5 in order.
REQ-040 PE 2 and PE 4 request on the same cycle after a PE 3 grant -> PE 4 is served before PE 2.
REQ-041 Request with dest=9, opcode=7, or from a PE whose counter is 5 -> no packet sent; drop_cnt increments when stats are enabled.
REQ-042 Full run with out_ready toggling every other cycle -> 25 input packets and 5 done packets per timestep, two ts_done pulses, cur_ts 0 then 1, then busy falls.
REQ-043 Drop rst_n while out_valid=1 and out_ready=0 -> outputs zero that cycle; a fresh start replays PRIME from PE 0.

Source files
------------

// File: rtl/imem_sched_pkg.sv
// imem_sched_pkg: packet layout, opcodes, row width and FSM states for the input-memory scheduler.
package imem_sched_pkg;
    localparam int PKT_W     = 33;
    localparam int DEST_HI   = 32;
    localparam int DEST_LO   = 29;
    localparam int OP_HI     = 28;
    localparam int OP_LO     = 25;
    localparam int ROW_W     = 25;
    localparam int ADDR_W    = 5;
    localparam int MEM_DEPTH = 32;
    localparam int IMEM_ID   = 10;
    localparam logic [3:0] OP_WEIGHT        = 4'd0;
    localparam logic [3:0] OP_INPUT         = 4'd1;
    localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;
    typedef enum logic [2:0] {IDLE, PRIME, SERVE, BCAST, FINISH} state_t;
endpackage

// File: rtl/imem_sched_rr_arbiter.sv
// rr_arbiter: N-way round-robin pick; search starts at the PE after the last taken grant.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          take,
    output logic [IW-1:0] gnt,
    output logic          gnt_vld
);
    logic [IW-1:0] ptr;
    int off, best;
    always_comb begin
        gnt = '0;
        gnt_vld = 1'b0;
        off = 0;
        best = N;
        for (int p = 0; p < N; p++) begin
            off = (p + N - int'(ptr)) % N;
            if (req[p] && off < best) begin
                best = off;
                gnt = IW'(p);
                gnt_vld = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (take) ptr <= (gnt >= IW'(N - 1)) ? '0 : gnt + IW'(1);
endmodule

// File: rtl/imem_sched.sv
// imem_sched: primes each PE with a row, serves row requests round-robin, broadcasts timestep-done.
// Define IMEM_SCHED_STATS_EN to add the saturating drop_cnt output.
module imem_sched #(
    parameter int NUM_PE      = 5,
    parameter int ROWS_PER_TS = 5,
    parameter int NUM_TS      = 2,
    parameter int IMEM_ID     = imem_sched_pkg::IMEM_ID
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [imem_sched_pkg::PKT_W-1:0]  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [imem_sched_pkg::PKT_W-1:0]  out_data,
    input  logic                              row_we,
    input  logic [imem_sched_pkg::ADDR_W-1:0] row_waddr,
    input  logic [imem_sched_pkg::ROW_W-1:0]  row_wdata,
    output logic                              busy,
    output logic [1:0]                        cur_ts,
    output logic                              ts_done
`ifdef IMEM_SCHED_STATS_EN
    ,
    output logic [7:0]                        drop_cnt
`endif
);
    import imem_sched_pkg::*;
    localparam int IW = $clog2(NUM_PE + 1);
    localparam int CW = $clog2(ROWS_PER_TS + 1);
    state_t state, state_n;
    logic [IW-1:0] pe_idx, form_pe, gnt;
    logic [3:0] form_op;
    logic form, gnt_vld, all_done, acc_in, acc_out, clr_all;
    logic [CW-1:0] cnt [NUM_PE];
    logic [CW-1:0] sel_cnt;
    logic [NUM_PE-1:0] pend, inc, set, clr;
    logic [ROW_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic unused_bits;
    assign unused_bits = ^in_data[OP_LO-1:0];
    assign acc_in   = in_valid && in_ready;
    assign acc_out  = out_valid && out_ready;
    assign in_ready = state == PRIME || state == SERVE;
    assign busy     = state != IDLE && state != FINISH;
    assign clr_all  = (state == IDLE && start) || (state == BCAST && state_n == PRIME);
    always_ff @(posedge clk)
        if (row_we) mem[row_waddr] <= row_wdata;
    // Request eligibility sees this edge's counter increment, so a PE cannot overrun its row quota.
    always_comb begin
        all_done = 1'b1;
        sel_cnt = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            inc[p] = acc_out && out_data[OP_HI:OP_LO] == OP_INPUT && out_data[DEST_HI:DEST_LO] == 4'(p);
            clr[p] = inc[p] && state == SERVE;
            set[p] = acc_in && in_data[DEST_HI:DEST_LO] == 4'(IMEM_ID) && in_data[OP_HI:OP_LO] == 4'(p)
                     && (cnt[p] + CW'(inc[p])) < CW'(ROWS_PER_TS);
            if (cnt[p] != CW'(ROWS_PER_TS)) all_done = 1'b0;
            if (form_pe == IW'(p)) sel_cnt = cnt[p];
        end
    end
    assign rd_addr = ADDR_W'(form_pe) + ADDR_W'(sel_cnt);
    rr_arbiter #(.N(NUM_PE), .IW(IW)) u_arb (
        .clk(clk), .rst_n(rst_n), .req(pend), .take(form && state == SERVE),
        .gnt(gnt), .gnt_vld(gnt_vld)
    );
    // A new packet is only formed into an empty output slot.
    always_comb begin
        state_n = state;
        form = 1'b0;
        form_pe = pe_idx;
        form_op = OP_INPUT;
        case (state)
            IDLE:   state_n = start ? PRIME : IDLE;
            PRIME:  if (!out_valid) begin
                        if (pe_idx == IW'(NUM_PE)) state_n = SERVE;
                        else form = 1'b1;
                    end
            SERVE:  if (!out_valid) begin
                        if (gnt_vld) begin
                            form = 1'b1;
                            form_pe = gnt;
                        end else if (all_done) state_n = BCAST;
                    end
            BCAST:  if (!out_valid) begin
                        if (pe_idx == IW'(NUM_PE)) state_n = (int'(cur_ts) + 1 < NUM_TS) ? PRIME : FINISH;
                        else begin
                            form = 1'b1;
                            form_op = OP_TIMESTEP_DONE;
                        end
                    end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            pe_idx <= '0;
            pend <= '0;
            cur_ts <= '0;
            ts_done <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            for (int p = 0; p < NUM_PE; p++) cnt[p] <= '0;
        end else begin
            state <= state_n;
            ts_done <= state == BCAST && state_n != BCAST;
            pe_idx <= (state_n != state) ? '0 : pe_idx + IW'(form && state != SERVE);
            pend <= (state == IDLE && start) ? '0 : (pend & ~clr) | set;
            cur_ts <= (state == IDLE && start) ? '0 : cur_ts + 2'(state == BCAST && state_n == PRIME);
            for (int p = 0; p < NUM_PE; p++) cnt[p] <= clr_all ? '0 : cnt[p] + CW'(inc[p]);
            if (acc_out) out_valid <= 1'b0;
            if (form) begin
                out_valid <= 1'b1;
                out_data <= {4'(form_pe), form_op, form_op == OP_INPUT ? mem[rd_addr] : ROW_W'(0)};
            end
        end
`ifdef IMEM_SCHED_STATS_EN
    logic drop;
    assign drop = acc_in && set == '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) drop_cnt <= '0;
        else if (state == IDLE && start) drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_imem_sched.sv
// tb_imem_sched: directed stimulus with a packet-level scheduler model checked every cycle on the falling edge.
module tb_imem_sched;
    localparam int NPE = 5;
    localparam int NTS = 2;
    logic clk, rst_n, start, in_valid, in_ready, out_valid, out_ready, row_we, busy, ts_done;
    logic [32:0] in_data, out_data;
    logic [4:0] row_waddr;
    logic [24:0] row_wdata;
    logic [1:0] cur_ts;
`ifdef IMEM_SCHED_STATS_EN
    logic [7:0] drop_cnt;
`endif
    imem_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .row_we(row_we), .row_waddr(row_waddr), .row_wdata(row_wdata), .busy(busy),
        .cur_ts(cur_ts), .ts_done(ts_done)
`ifdef IMEM_SCHED_STATS_EN
        , .drop_cnt(drop_cnt)
`endif
    );
    initial clk = 0;
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask
    task automatic bad(input string nm, input logic [63:0] got);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected packet %0h at %0t", nm, got, $time);
    endtask
    // Model: phase 0 idle, 1 prime, 2 serve, 3 broadcast, 4 between timesteps / finished
    int phase, m_ts, prime_idx, bc_idx, rr_next, drops_exp, dones, dones_in_ts, tsd_cnt;
    int cnt[NPE], snap_cnt[NPE], in_cnt[NTS];
    bit pend[NPE], snap_pend[NPE];
    bit pv, pacc, pserve;
    bit [1:0] cur_seen;
    logic [32:0] pdata;
    logic [24:0] mm[32];
    logic [32:0] acc_log[$];
    function automatic int rr_pick();
        for (int i = 0; i < NPE; i++) if (snap_pend[(rr_next + i) % NPE]) return (rr_next + i) % NPE;
        return -1;
    endfunction
    task automatic new_pkt(input logic [32:0] pk);
        int p;
        bit full;
        if (phase == 4 && m_ts < NTS - 1) begin
            m_ts++;
            phase = 1;
            prime_idx = 0;
            dones_in_ts = 0;
            for (int i = 0; i < NPE; i++) begin cnt[i] = 0; snap_cnt[i] = 0; end
        end
        full = 1;
        for (int i = 0; i < NPE; i++) if (snap_cnt[i] != 5) full = 0;
        if (phase == 2 && full) begin phase = 3; bc_idx = 0; end
        chk("cur_ts", cur_ts, m_ts);
        case (phase)
            1: begin
                p = prime_idx;
                chk("prime_dest", pk[32:29], p);
                chk("prime_op", pk[28:25], 1);
                chk("prime_data", pk[24:0], mm[p + snap_cnt[p]]);
                pserve = 0;
                prime_idx++;
                if (prime_idx == NPE) phase = 2;
            end
            2: begin
                p = rr_pick();
                if (p < 0) bad("serve_spurious", pk);
                else begin
                    chk("serve_dest", pk[32:29], p);
                    chk("serve_op", pk[28:25], 1);
                    chk("serve_data", pk[24:0], mm[p + snap_cnt[p]]);
                    rr_next = (p + 1) % NPE;
                end
                pserve = 1;
            end
            3: begin
                chk("bcast_dest", pk[32:29], bc_idx);
                chk("bcast_op", pk[28:25], 15);
                chk("bcast_data", pk[24:0], 0);
                pserve = 0;
                bc_idx++;
                if (bc_idx == NPE) phase = 4;
            end
            default: bad("idle_spurious", pk);
        endcase
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            phase = 0; m_ts = 0; rr_next = 0; drops_exp = 0; pv = 0; pacc = 0; pserve = 0;
            for (int i = 0; i < NPE; i++) begin cnt[i] = 0; pend[i] = 0; snap_cnt[i] = 0; snap_pend[i] = 0; end
        end else begin
            if (out_valid && (!pv || pacc)) new_pkt(out_data);
            if (pv && !pacc) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pdata);
            end
`ifdef IMEM_SCHED_STATS_EN
            chk("drop_cnt", drop_cnt, drops_exp);
`endif
            if (ts_done) begin
                chk("ts_done_after_bcast", dones_in_ts, NPE);
                tsd_cnt++;
            end
            if (busy) cur_seen[cur_ts] = 1'b1;
            snap_pend = pend;
            snap_cnt = cnt;
            if (start && (phase == 0 || (phase == 4 && m_ts == NTS - 1))) begin
                phase = 1; prime_idx = 0; m_ts = 0; drops_exp = 0; dones_in_ts = 0;
                for (int i = 0; i < NPE; i++) begin cnt[i] = 0; pend[i] = 0; end
            end
            if (out_valid && out_ready) begin
                acc_log.push_back(out_data);
                if (out_data[28:25] == 4'd1 && out_data[32:29] < NPE) begin
                    cnt[out_data[32:29]]++;
                    if (pserve) pend[out_data[32:29]] = 0;
                    if (m_ts < NTS) in_cnt[m_ts]++;
                end else if (out_data[28:25] == 4'd15) begin
                    dones++;
                    dones_in_ts++;
                end
            end
            if (in_valid && in_ready) begin
                if (in_data[32:29] == 4'd10 && in_data[28:25] < NPE && cnt[in_data[28:25]] < 5) pend[in_data[28:25]] = 1;
                else if (drops_exp < 255) drops_exp++;
            end
            if (row_we) mm[row_waddr] = row_wdata;
            pv = out_valid;
            pacc = out_valid && out_ready;
            pdata = out_data;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send_req(input logic [3:0] d, input logic [3:0] o);
        bit hs = 0;
        in_data = {d, o, 25'd0};
        in_valid = 1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready;
            tick();
        end
        in_valid = 0;
        chk("req_handshake", hs, 1);
    endtask
    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask
    int n0, pe;
    bit hs;
    initial begin
        rst_n = 0; start = 0; in_valid = 0; in_data = '0; out_ready = 0;
        row_we = 0; row_waddr = '0; row_wdata = '0; tsd_cnt = 0; dones = 0; cur_seen = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_ts", cur_ts, 0);
        chk("rst_ts_done", ts_done, 0);
        tick();
        rst_n = 1;
        for (int r = 0; r < 32; r++) begin
            row_we = 1; row_waddr = 5'(r); row_wdata = 25'(r + 1);
            tick();
        end
        row_we = 0;
        // Prime: PEs 0..4 receive rows 1..5
        out_ready = 1;
        pulse_start();
        for (int i = 0; i < 100 && acc_log.size() < 5; i++) tick();
        chk("prime_count", acc_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < acc_log.size(); i++) chk("prime_lit", acc_log[i], {4'(i), 4'd1, 25'(i + 1)});
        // Round robin: after PE 3 is granted, pending PEs 2 and 4 go 4 then 2
        out_ready = 0;
        send_req(4'd10, 4'd3);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("pe3_granted", out_valid, 1);
        send_req(4'd10, 4'd2);
        send_req(4'd10, 4'd4);
        out_ready = 1;
        for (int i = 0; i < 100 && acc_log.size() < 8; i++) tick();
        chk("rr_count", acc_log.size() >= 8, 1);
        if (acc_log.size() >= 8) begin
            chk("rr_first_pe3", acc_log[5], {4'd3, 4'd1, 25'd5});
            chk("rr_second_pe4", acc_log[6], {4'd4, 4'd1, 25'd6});
            chk("rr_third_pe2", acc_log[7], {4'd2, 4'd1, 25'd4});
        end
        // Drops: wrong dest, out-of-range opcode
        n0 = acc_log.size();
        send_req(4'd9, 4'd0);
        send_req(4'd10, 4'd7);
        repeat (6) tick();
        chk("drop_no_valid", out_valid, 0);
        chk("drop_no_pkt", acc_log.size(), n0);
        // Repeat request while pending is absorbed
        out_ready = 0;
        send_req(4'd10, 4'd1);
        send_req(4'd10, 4'd1);
        out_ready = 1;
        repeat (8) tick();
        chk("repeat_absorbed", acc_log.size(), n0 + 1);
        // Fill PE 0 to its quota, then its next request drops
        for (int k = 0; k < 4; k++) begin
            n0 = acc_log.size();
            send_req(4'd10, 4'd0);
            for (int i = 0; i < 20 && acc_log.size() == n0; i++) tick();
            chk("pe0_fill", acc_log.size(), n0 + 1);
        end
        n0 = acc_log.size();
        send_req(4'd10, 4'd0);
        repeat (6) tick();
        chk("quota_no_valid", out_valid, 0);
        chk("quota_no_pkt", acc_log.size(), n0);
`ifdef IMEM_SCHED_STATS_EN
        chk("drop_cnt_lit", drop_cnt, 3);
`endif
        // Full run with out_ready toggling
        pe = 0;
        for (int i = 0; i < 4000 && busy; i++) begin
            in_data = {4'd10, 4'(pe), 25'd0};
            in_valid = 1;
            @(negedge clk);
            hs = in_ready;
            tick();
            if (hs) pe = (pe + 1) % NPE;
            out_ready = ~out_ready;
        end
        in_valid = 0;
        out_ready = 1;
        chk("run_busy_fell", busy, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("ts0_inputs", in_cnt[0], 25);
        chk("ts1_inputs", in_cnt[1], 25);
        chk("done_pkts", dones, 10);
        chk("ts_done_pulses", tsd_cnt, 2);
        chk("cur_ts_seen", cur_seen, 2'b11);
        // Reset mid-packet, then a fresh start replays PRIME from PE 0
        out_ready = 0;
        pulse_start();
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("stall_valid", out_valid, 1);
        #3 rst_n = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        rst_n = 1;
        out_ready = 1;
        n0 = acc_log.size();
        pulse_start();
        for (int i = 0; i < 20 && acc_log.size() == n0; i++) tick();
        chk("replay_count", acc_log.size(), n0 + 1);
        if (acc_log.size() > n0) chk("replay_pe0", acc_log[n0], {4'd0, 4'd1, 25'd1});
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
